// File: rtl/lane_transposer_pp.sv
// Streaming LANES x LANES corner-turn with ping-pong banks, valid/ready on both
// sides, per-frame transpose/bypass selection and in_sop-driven frame resync.
module lane_transposer_pp #(
  parameter int WIDTH = 32,
  parameter int LANES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sop,
  input  logic                     in_mode,
  input  logic [LANES*WIDTH-1:0]   in_re,
  input  logic [LANES*WIDTH-1:0]   in_img,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic [LANES*WIDTH-1:0]   out_re,
  output logic [LANES*WIDTH-1:0]   out_img,
  output logic                     err_resync
);

  localparam int CW = $clog2(LANES);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(LANES - 1);

  logic [WIDTH-1:0] re_q  [2][LANES][LANES];
  logic [WIDTH-1:0] re_d  [2][LANES][LANES];
  logic [WIDTH-1:0] img_q [2][LANES][LANES];
  logic [WIDTH-1:0] img_d [2][LANES][LANES];

  logic [1:0] full_q, full_d;
  logic [1:0] mode_q, mode_d;
  logic       wb_q, wb_d;
  logic       rb_q, rb_d;
  cnt_t       wr_cnt_q, wr_cnt_d;
  cnt_t       rd_cnt_q, rd_cnt_d;
  logic       err_q, err_d;

  logic accept;
  logic resync;
  logic rd_fire;
  cnt_t wr_row;

  assign in_ready   = !full_q[wb_q];
  assign out_valid  = full_q[rb_q];
  assign err_resync = err_q;

  always_comb begin
    re_d     = re_q;
    img_d    = img_q;
    full_d   = full_q;
    mode_d   = mode_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;

    accept  = in_valid && in_ready;
    resync  = accept && in_sop && (wr_cnt_q != '0);
    rd_fire = out_valid && out_ready;
    err_d   = resync;
    // A resync beat restarts the current bank at row 0 instead of advancing.
    wr_row  = resync ? '0 : wr_cnt_q;

    if (accept) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        re_d[wb_q][wr_row][j]  = in_re[j*WIDTH +: WIDTH];
        img_d[wb_q][wr_row][j] = in_img[j*WIDTH +: WIDTH];
      end
      if (wr_row == '0) mode_d[wb_q] = in_mode;
      if (resync) begin
        wr_cnt_d = cnt_t'(1);
      end else if (wr_cnt_q == LAST) begin
        full_d[wb_q] = 1'b1;
        wb_d         = !wb_q;
        wr_cnt_d     = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + cnt_t'(1);
      end
    end

    // Write and read completions always target different banks, so both apply.
    if (rd_fire) begin
      if (rd_cnt_q == LAST) begin
        full_d[rb_q] = 1'b0;
        rb_d         = !rb_q;
        rd_cnt_d     = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + cnt_t'(1);
      end
    end
  end

  always_comb begin
    out_sop = out_valid && (rd_cnt_q == '0);
    out_re  = '0;
    out_img = '0;
    if (out_valid) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (mode_q[rb_q]) begin
          out_re[k*WIDTH +: WIDTH]  = re_q[rb_q][k][rd_cnt_q];
          out_img[k*WIDTH +: WIDTH] = img_q[rb_q][k][rd_cnt_q];
        end else begin
          out_re[k*WIDTH +: WIDTH]  = re_q[rb_q][rd_cnt_q][k];
          out_img[k*WIDTH +: WIDTH] = img_q[rb_q][rd_cnt_q][k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      mode_q   <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      mode_q   <= mode_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    re_q  <= re_d;
    img_q <= img_d;
  end

endmodule

// File: tb/tb_lane_transposer_pp.sv
// Bench for lane_transposer_pp: a directed vector table, hand-written corner
// sequences and random traffic checked against a frame-level reference model.
module tb_lane_transposer_pp;

  localparam int W = 32;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_sop = 1'b0;
  logic           in_mode = 1'b0;
  logic [L*W-1:0] in_re = '0;
  logic [L*W-1:0] in_img = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           out_sop;
  logic [L*W-1:0] out_re;
  logic [L*W-1:0] out_img;
  logic           err_resync;

  lane_transposer_pp #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_mode(in_mode),
    .in_re(in_re), .in_img(in_img),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_re(out_re), .out_img(out_img), .err_resync(err_resync)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [L*W-1:0] pk(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  // ---------------- reference model: frames of rows, transposed as a whole
  typedef struct {
    logic [L*W-1:0] re;
    logic [L*W-1:0] im;
    bit             sop;
  } beat_t;

  beat_t          exq[$];
  logic [W-1:0]   p_re[L][L];
  logic [W-1:0]   p_im[L][L];
  int             pcnt = 0;
  bit             pmode = 1'b0;
  bit             err_exp = 1'b0;
  int             err_seen = 0;

  function automatic int banks_used();
    return (exq.size() + L - 1) / L;
  endfunction

  task automatic model_accept(input bit sop, input bit md,
                              input logic [L*W-1:0] re, input logic [L*W-1:0] im);
    beat_t b;
    if (sop && pcnt != 0) pcnt = 0;
    if (pcnt == 0) pmode = md;
    for (int j = 0; j < L; j++) begin
      p_re[pcnt][j] = re[j*W +: W];
      p_im[pcnt][j] = im[j*W +: W];
    end
    pcnt++;
    if (pcnt == L) begin
      for (int r = 0; r < L; r++) begin
        for (int k = 0; k < L; k++) begin
          b.re[k*W +: W] = pmode ? p_re[k][r] : p_re[r][k];
          b.im[k*W +: W] = pmode ? p_im[k][r] : p_im[r][k];
        end
        b.sop = (r == 0);
        exq.push_back(b);
      end
      pcnt = 0;
    end
  endtask

  // One clock: drive, compare current-cycle outputs against the model, advance.
  task automatic step(input bit v, input bit sop, input bit md,
                      input logic [L*W-1:0] re, input logic [L*W-1:0] im,
                      input bit ordy, input bit r, output bit acc);
    bit e_rdy, e_ov, fire, nerr;
    in_valid = v; in_sop = sop; in_mode = md; in_re = re; in_img = im;
    out_ready = ordy; rst = r;
    e_rdy = banks_used() < 2;
    e_ov  = exq.size() > 0;
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, e_ov);
    chk("out_sop", out_sop, e_ov ? exq[0].sop : 1'b0);
    chk("out_re", out_re, e_ov ? exq[0].re : '0);
    chk("out_img", out_img, e_ov ? exq[0].im : '0);
    chk("err_resync", err_resync, err_exp);
    if (err_resync) err_seen++;
    acc  = v && e_rdy && !r;
    fire = e_ov && ordy;
    nerr = acc && sop && (pcnt != 0);
    @(posedge clk);
    if (r) begin
      exq.delete();
      pcnt = 0;
      err_exp = 1'b0;
    end else begin
      if (fire) void'(exq.pop_front());
      if (acc) model_accept(sop, md, re, im);
      err_exp = nerr;
    end
    #1;
  endtask

  function automatic logic [L*W-1:0] rnd();
    logic [L*W-1:0] x;
    for (int j = 0; j < L; j++) x[j*W +: W] = $urandom;
    return x;
  endfunction

  // Hold a row on the input until accepted, with a bounded wait.
  task automatic feed_row(input bit sop, input bit md, input logic [L*W-1:0] re,
                          input logic [L*W-1:0] im, input bit ordy);
    bit a;
    int t;
    a = 1'b0;
    t = 0;
    while (!a && t < 50) begin
      step(1'b1, sop, md, re, im, ordy, 1'b0, a);
      t++;
    end
    if (!a) begin
      total++;
      bad++;
      $display("FAIL feed_timeout: got accepted=0 want accepted=1 at %0t", $time);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, ordy, 1'b0, a);
  endtask

  // ---------------- directed vector table
  typedef struct {
    bit v, sop, md, ordy;
    int a, b, c;
    bit e_rdy, e_ov, e_sop;
    int x, y, z;
  } vec_t;

  function automatic vec_t mk(bit v, bit sop, bit md, bit ordy, int a, int b, int c,
                              bit e_rdy, bit e_ov, bit e_sop, int x, int y, int z);
    vec_t t;
    t.v = v; t.sop = sop; t.md = md; t.ordy = ordy;
    t.a = a; t.b = b; t.c = c;
    t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_sop = e_sop;
    t.x = x; t.y = y; t.z = z;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    bit a;
    int accepted, err0;
    logic [L*W-1:0] r0, r1, r2;

    // transpose frame, then a bypass frame whose in_mode toggles on rows 1-2
    tbl[0] = mk(1,1,1,0, 0,1,2, 1,0,0, 0,0,0);
    tbl[1] = mk(1,0,1,0, 3,4,5, 1,0,0, 0,0,0);
    tbl[2] = mk(1,0,1,0, 6,7,8, 1,0,0, 0,0,0);
    tbl[3] = mk(1,1,0,1, 0,1,2, 1,1,1, 0,3,6);
    tbl[4] = mk(1,0,1,1, 3,4,5, 1,1,0, 1,4,7);
    tbl[5] = mk(1,0,1,1, 6,7,8, 1,1,0, 2,5,8);
    tbl[6] = mk(0,0,0,1, 0,0,0, 1,1,1, 0,1,2);
    tbl[7] = mk(0,0,0,1, 0,0,0, 1,1,0, 3,4,5);
    tbl[8] = mk(0,0,0,1, 0,0,0, 1,1,0, 6,7,8);
    tbl[9] = mk(0,0,0,1, 0,0,0, 1,0,0, 0,0,0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].v;
      in_sop    = tbl[i].sop;
      in_mode   = tbl[i].md;
      out_ready = tbl[i].ordy;
      in_re     = tbl[i].v ? pk(tbl[i].a, tbl[i].b, tbl[i].c) : '0;
      in_img    = tbl[i].v ? pk(tbl[i].a + 100, tbl[i].b + 100, tbl[i].c + 100) : '0;
      chk("tbl_in_ready", in_ready, tbl[i].e_rdy);
      chk("tbl_out_valid", out_valid, tbl[i].e_ov);
      chk("tbl_out_sop", out_sop, tbl[i].e_sop);
      chk("tbl_out_re", out_re, tbl[i].e_ov ? pk(tbl[i].x, tbl[i].y, tbl[i].z) : '0);
      chk("tbl_out_img", out_img,
          tbl[i].e_ov ? pk(tbl[i].x + 100, tbl[i].y + 100, tbl[i].z + 100) : '0);
      chk("tbl_err", err_resync, 1'b0);
      @(posedge clk);
      #1;
    end

    // streaming: 4 back-to-back frames, downstream always ready
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < L; r++) feed_row(r == 0, f[0], rnd(), rnd(), 1'b1);
    idle(L + 2, 1'b1);

    // backpressure: only two frames fit while downstream is stalled
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (accepted % L) == 0, 1'b1, rnd(), rnd(), 1'b0, 1'b0, a);
      if (a) accepted++;
    end
    chk("bp_accepts", accepted, 6);
    for (int r = 0; r < L; r++) feed_row(r == 0, 1'b1, rnd(), rnd(), 1'b1);
    idle(3 * L + 2, 1'b1);

    // resync: two rows then a fresh in_sop row of 9s
    err0 = err_seen;
    feed_row(1'b1, 1'b1, pk(1,2,3), pk(101,102,103), 1'b1);
    feed_row(1'b0, 1'b1, pk(4,5,6), pk(104,105,106), 1'b1);
    feed_row(1'b1, 1'b1, pk(9,9,9), pk(109,109,109), 1'b1);
    feed_row(1'b0, 1'b1, pk(10,11,12), pk(110,111,112), 1'b1);
    feed_row(1'b0, 1'b1, pk(13,14,15), pk(113,114,115), 1'b1);
    idle(L + 2, 1'b1);
    chk("resync_pulses", err_seen - err0, 1);

    // reset while draining, then a clean frame
    r0 = rnd(); r1 = rnd(); r2 = rnd();
    feed_row(1'b1, 1'b1, r0, r1, 1'b1);
    feed_row(1'b0, 1'b1, r1, r2, 1'b1);
    feed_row(1'b0, 1'b1, r2, r0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, a);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, a);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_re", out_re, '0);
    for (int r = 0; r < L; r++) feed_row(r == 0, 1'b1, rnd(), rnd(), 1'b1);
    idle(L + 2, 1'b1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 8) == 0, $urandom % 2, rnd(), rnd(),
           ($urandom % 4) != 0, ($urandom % 500) == 0, a);
    end
    idle(2 * L + 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_transposer_pp.md
Name: lane_transposer_pp

Overview:
- Parametrised streaming corner-turn (transposer) for the multi-lane radix-3^k FFT pipelines.
- Successor to the fixed 3-lane shuffler driven by external selects. All sequencing is generated internally; the block adds valid/ready handshake, ping-pong double buffering, per-frame bypass mode and frame resynchronisation.
- Sits between a radix-R butterfly stage and the twiddle multipliers.
- Accepts R beats of R complex lanes (an RxR matrix) and emits the transposed matrix at full throughput.

Parameters:
- WIDTH, 32, bits per real/imag component (two's complement, passed through unmodified).
- LANES, 3, radix R: lanes per beat and beats per frame; legal 2..8.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sop  in  1  marks first beat (row 0) of a frame.
- in_mode  in  1  1 = transpose, 0 = bypass; sampled on row 0 of each frame.
- in_re  in  LANES*WIDTH  real parts; lane j at bits [j*WIDTH +: WIDTH].
- in_img  in  LANES*WIDTH  imag parts, same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_sop  out  1  first beat of output frame.
- out_re  out  LANES*WIDTH  real parts, same packing.
- out_img  out  LANES*WIDTH  imag parts, same packing.
- err_resync  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Storage: two banks, each LANES x LANES complex words.
- Per-bank registers: full flag and mode bit.
- Write side: bank pointer wb, row counter wr_cnt (0..LANES-1).
- Read side: bank pointer rb, row counter rd_cnt.
- Reset (rst=1 at clock edge): wb=rb=0, wr_cnt=rd_cnt=0, both full flags 0, err_resync=0. Bank contents are not reset.
- Since full flags clear on reset, out_valid=0, out_sop=0 and in_ready=1 in the cycle after reset. Reset mid-frame discards all buffered data.
- in_ready = !full[wb]. Accept = in_valid && in_ready.
- On accept:
  - Lane j is written to bank[wb][wr_cnt][j].
  - On row 0, in_mode is latched into mode[wb].
  - If wr_cnt==LANES-1: full[wb]<=1, wb toggles, wr_cnt<=0. Otherwise wr_cnt increments.
- Resync: in_sop=1 on an accepted beat with wr_cnt!=0.
  - The partial frame is discarded.
  - The beat is written as row 0 of the same bank (mode latched), wr_cnt<=1.
  - err_resync pulses for one cycle.
- in_sop=0 on a beat with wr_cnt==0 is accepted as row 0 with no error. in_sop is only a resync hint.
- out_valid = full[rb]. out_sop = out_valid && rd_cnt==0.
- Output lane k on read row r:
  - mode[rb]=1: bank[rb][k][r] (transpose).
  - mode[rb]=0: bank[rb][r][k] (bypass).
- Output data is a combinational mux from registers and is forced to 0 when out_valid=0.
- On out_valid && out_ready: at rd_cnt==LANES-1, full[rb]<=0, rb toggles, rd_cnt<=0. Otherwise rd_cnt increments.
- Latency: first output beat is valid in the cycle after the accept of the frame's last input beat. There is no combinational in->out path.
- Throughput: with out_ready held high, continuous input at one beat per cycle is sustained with in_ready never deasserting. Frames are output back-to-back.
- Full condition: both banks full implies in_ready=0. in_ready rises in the cycle after the last row of the read bank is consumed.
- Simultaneous events:
  - Write-complete and read-complete in the same cycle act on different banks; both updates apply.
  - wb==rb cannot coincide with a bank being both written and read.
- Stall: while out_valid && !out_ready, outputs hold stable.
- No arithmetic is performed; widths pass through bit-exact.

Test Plan:
- Reset then a single transpose frame (LANES=3, mode=1). Input rows {0,1,2},{3,4,5},{6,7,8} in re, with img = re+100. Required output rows {0,3,6},{1,4,7},{2,5,8}, out_sop on first output row, first out_valid one cycle after last accept.
- Bypass frame (mode=0), same data -> output rows equal input rows. Mode is sampled only on row 0: toggling in_mode on rows 1-2 has no effect.
- Streaming: 4 back-to-back frames, out_ready=1 -> in_ready stays 1 throughout, 12 output beats contiguous, each frame correctly transposed, in order.
- Backpressure: out_ready=0 while feeding 3 frames -> in_ready drops after 6 accepts. Raising out_ready drains rows in order with held-stable data during the stall; in_ready returns one cycle after the third drained row.
- Resync: send 2 rows then in_sop with row {9,9,9} -> err_resync pulses once, the partial frame is never output, and the new frame starting {9,9,9} is output transposed.
- Reset mid-drain: assert rst while out_valid=1 -> next cycle out_valid=0, outputs 0, in_ready=1; a subsequent frame is output correctly.
